// File: rtl/dsp_acc_pkg.sv
// Shared types and the round/shift/clamp helper for the accumulator drain path.
package dsp_acc_pkg;

    localparam int ACC_W     = 48;
    localparam int PIX_MAX_W = 16;

    localparam logic [ACC_W:0] ACC_ONE = {{ACC_W{1'b0}}, 1'b1};

    typedef struct packed {
        logic last;
        logic sof;
        logic eol;
    } acc_tag_t;

    typedef struct packed {
        logic                 clamp;
        logic [PIX_MAX_W-1:0] pix;
    } sat_t;

    // Round half-up, arithmetic shift, then clamp to [0, 2^out_w-1]; done at ACC_W+1 bits
    // so the rounding add can never wrap.
    function automatic sat_t sat_round(input logic signed [ACC_W-1:0] acc,
                                       input int                      frac_bits,
                                       input int                      out_w);
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] max_v;
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] q;
        sat_t                  res;
        half  = ACC_ONE << (frac_bits - 1);
        max_v = (ACC_ONE << out_w) - ACC_ONE;
        r     = {acc[ACC_W-1], acc} + half;
        q     = r >>> frac_bits;
        res   = '0;
        if (q[ACC_W]) begin
            res.clamp = 1'b1;
        end else if (q > max_v) begin
            res.clamp = 1'b1;
            res.pix   = max_v[PIX_MAX_W-1:0];
        end else begin
            res.pix   = q[PIX_MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count; read data reads as zero when empty.
module sync_fifo_fwft #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; the empty gate below keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/dsp_acc_drain.sv
// Result drain for the bicubic accumulator: tag delay line, pixel formatter, output FIFO and
// accumulator clock-enable back-pressure.
module dsp_acc_drain
    import dsp_acc_pkg::*;
#(
    parameter int ACC_LATENCY = 3,
    parameter int FRAC_BITS   = 8,
    parameter int OUT_W       = 8,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_issue,
    input  logic                    s_last,
    input  logic                    s_sof,
    input  logic                    s_eol,
    input  logic signed [ACC_W-1:0] acc_result,
    output logic                    acc_clken,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [OUT_W-1:0]        m_data,
    output logic                    m_sof,
    output logic                    m_eol,
    output logic                    ovf_sticky
);

    localparam int FW = OUT_W + 2;
    localparam int CW = $clog2(DEPTH + 1);

    acc_tag_t      tag_q [ACC_LATENCY];
    acc_tag_t      tag_in;
    acc_tag_t      tag_out;
    logic          capture;
    sat_t          fmt;
    logic [FW-1:0] wr_data;
    logic [FW-1:0] rd_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    assign tag_in = '{last: s_issue & s_last, sof: s_sof, eol: s_eol};

    // The delay line freezes together with the accumulator pipeline, so the final stage
    // always lines up with the sum currently on acc_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ACC_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (acc_clken) begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < ACC_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[ACC_LATENCY-1];
    assign capture = acc_clken & tag_out.last;
    assign fmt     = sat_round(acc_result, FRAC_BITS, OUT_W);
    assign wr_data = {tag_out.sof, tag_out.eol, fmt.pix[OUT_W-1:0]};

    generate
        if (OUT_W < PIX_MAX_W) begin : g_pix_unused
            logic pix_hi_unused;
            assign pix_hi_unused = ^fmt.pix[PIX_MAX_W-1:OUT_W];
        end
    endgenerate

    // Stream contract: m_valid rises only with a queued pixel and falls only after a
    // m_valid & m_ready pop; m_data/m_sof/m_eol stay frozen while m_valid & !m_ready.
    assign push = capture & ~fifo_full;
    assign pop  = m_valid & m_ready;

    sync_fifo_fwft #(
        .W     (FW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (capture),
        .wr_data (wr_data),
        .rd_en   (m_ready),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = rd_data[OUT_W-1:0];
    assign m_eol   = rd_data[OUT_W];
    assign m_sof   = rd_data[OUT_W+1];

    // Threshold DEPTH-2 leaves room for the one pixel that can still land in the cycle
    // after acc_clken is seen to fall.
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_clken  <= 1'b1;
            ovf_sticky <= 1'b0;
        end else begin
            acc_clken <= (count_next <= CW'(DEPTH - 2));
            if (capture && fmt.clamp) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(capture && fifo_full));

endmodule

// File: tb/tb_dsp_acc_drain.sv
// Bench for dsp_acc_drain: models the accumulator pipeline, scoreboards formatted pixels.
module tb_dsp_acc_drain;

    localparam int L     = 3;
    localparam int FRAC  = 8;
    localparam int OUT_W = 8;
    localparam int DEPTH = 4;
    localparam int FW    = OUT_W + 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_issue, s_last, s_sof, s_eol;
    logic signed [47:0] acc_result;
    logic               acc_clken;
    logic               m_valid;
    logic               m_ready;
    logic [OUT_W-1:0]   m_data;
    logic               m_sof, m_eol;
    logic               ovf_sticky;

    logic signed [47:0] acc_in;
    logic signed [47:0] acc_pipe [L];
    logic [FW-1:0]      exp_q [$];
    logic               exp_ovf;
    logic               rand_ready;
    logic               hold_pend;
    logic [FW-1:0]      held;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    dsp_acc_drain #(
        .ACC_LATENCY (L),
        .FRAC_BITS   (FRAC),
        .OUT_W       (OUT_W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_issue    (s_issue),
        .s_last     (s_last),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .acc_result (acc_result),
        .acc_clken  (acc_clken),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .ovf_sticky (ovf_sticky)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // accumulator stand-in: result appears L enabled cycles after issue
    always @(posedge clk) begin
        if (acc_clken) begin
            acc_pipe[0] <= acc_in;
            for (int i = 1; i < L; i++) acc_pipe[i] <= acc_pipe[i-1];
        end
    end
    assign acc_result = acc_pipe[L-1];

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W:0] exp_pix(input longint v);
        longint q;
        longint maxv;
        q    = (v + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        maxv = (longint'(1) << OUT_W) - 1;
        if (q < 0) return {1'b1, {OUT_W{1'b0}}};
        if (q > maxv) return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, q[OUT_W-1:0]};
    endfunction

    // driver tasks
    task automatic try_issue(input logic last, input logic sof, input logic eol,
                             input longint val, output logic accepted);
        logic [OUT_W:0] e;
        s_issue = 1'b1;
        s_last  = last;
        s_sof   = sof;
        s_eol   = eol;
        acc_in  = val[47:0];
        @(negedge clk);
        accepted = acc_clken;
        @(posedge clk);
        #1;
        if (accepted && last) begin
            e = exp_pix(val);
            exp_q.push_back({sof, eol, e[OUT_W-1:0]});
            if (e[OUT_W]) exp_ovf = 1'b1;
        end
        s_issue = 1'b0;
        s_last  = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic issue(input logic last, input logic sof, input logic eol, input longint val);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 64) begin
            try_issue(last, sof, eol, val, acc);
            tries++;
        end
        if (!acc) check("issue_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_pixel(input longint val, input logic sof, input logic eol);
        for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, 1'b0, longint'($urandom_range(0, 9999)));
        issue(1'b1, sof, eol, val);
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'({m_sof, m_eol, m_data}), 32'(held));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(m_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'({m_sof, m_eol, m_data}), 32'(e));
                end
            end
            hold_pend = m_valid && !m_ready;
            held      = {m_sof, m_eol, m_data};
        end
    end

    initial begin
        logic acc;
        int   lat;
        int   n_acc;
        reset      = 1'b1;
        s_issue    = 1'b0;
        s_last     = 1'b0;
        s_sof      = 1'b0;
        s_eol      = 1'b0;
        acc_in     = '0;
        m_ready    = 1'b1;
        rand_ready = 1'b0;
        exp_ovf    = 1'b0;
        hold_pend  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_sof", 32'(m_sof), 32'd0);
        check("rst_eol", 32'(m_eol), 32'd0);
        check("rst_clken", 32'(acc_clken), 32'd1);
        check("rst_ovf", 32'(ovf_sticky), 32'd0);
        @(posedge clk);
        #1;

        // single pixel with latency measurement
        send_pixel(32896, 1'b0, 1'b0);
        lat = 1;
        @(negedge clk);
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(L + 1));
        check("m_data_129", 32'(m_data), 32'd129);
        wait_drain();
        check("ovf_after_129", 32'(ovf_sticky), 32'd0);

        // exact top of range, no clamp
        send_pixel(65407, 1'b0, 1'b0);
        wait_drain();
        check("ovf_65407", 32'(ovf_sticky), 32'(exp_ovf));

        // clamps
        send_pixel(-300, 1'b0, 1'b0);
        wait_drain();
        check("ovf_neg", 32'(ovf_sticky), 32'(exp_ovf));
        send_pixel(70000, 1'b0, 1'b0);
        wait_drain();

        // sideband alignment
        for (int p = 0; p < 4; p++)
            send_pixel(longint'($urandom_range(0, 66000)), p == 0, p == 3);
        wait_drain();

        // full-rate burst under random back-pressure
        rand_ready = 1'b1;
        for (int p = 0; p < 12; p++)
            issue(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  longint'($urandom_range(0, 80000)) - 5000);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain();
        check("ovf_burst", 32'(ovf_sticky), 32'(exp_ovf));

        // back-pressure: clken must fall with DEPTH-1 queued plus L in flight
        m_ready = 1'b0;
        n_acc   = 0;
        for (int i = 0; i < 10; i++) begin
            try_issue(1'b1, 1'b0, 1'b0, longint'($urandom_range(0, 65000)), acc);
            if (acc) n_acc++;
        end
        check("bp_accepted", 32'(n_acc), 32'(L + DEPTH - 1));
        @(negedge clk);
        check("bp_clken_low", 32'(acc_clken), 32'd0);
        check("bp_valid", 32'(m_valid), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            try_issue(1'($urandom_range(0, 1)), 1'b0, 1'b0, longint'($urandom_range(0, 65000)), acc);
            check("freeze_clken", 32'(acc), 32'd0);
        end
        m_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("bp_clken_back", 32'(acc_clken), 32'd1);
        @(posedge clk);
        #1;

        // reset with two queued and one in flight
        m_ready = 1'b0;
        try_issue(1'b1, 1'b0, 1'b0, -500, acc);
        check("rst_mid_acc0", 32'(acc), 32'd1);
        try_issue(1'b1, 1'b0, 1'b0, 20000, acc);
        check("rst_mid_acc1", 32'(acc), 32'd1);
        try_issue(1'b1, 1'b0, 1'b0, 30000, acc);
        check("rst_mid_acc2", 32'(acc), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        check("pre_rst_ovf", 32'(ovf_sticky), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(m_valid), 32'd0);
        check("post_rst_clken", 32'(acc_clken), 32'd1);
        check("post_rst_ovf", 32'(ovf_sticky), 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_pixel(32896, 1'b1, 1'b1);
        wait_drain();
        check("final_ovf", 32'(ovf_sticky), 32'(exp_ovf));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
